// File: rtl/du_pkg.sv
// -----------------------------------------------------------------------------
// du_pkg
// Shared definitions for the debug-unit latch dump path.
// - du_state_t   : dump sequencer states
// - DU_HDR_TAG   : upper nibble of every per-channel header byte
// - DU_CRC8_POLY : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
// - DU_CRC8_INIT : CRC-8 start value
// -----------------------------------------------------------------------------
package du_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      CRC,
      DONE
   } du_state_t;

   localparam logic [3:0] DU_HDR_TAG   = 4'hA;
   localparam logic [7:0] DU_CRC8_POLY = 8'h07;
   localparam logic [7:0] DU_CRC8_INIT = 8'h00;

endpackage

// File: rtl/du_crc8_byte.sv
// -----------------------------------------------------------------------------
// du_crc8_byte
// Purely combinational single-byte CRC-8 step, MSB first, no reflection.
// Ports:
// - crc      in  8  running CRC value
// - data     in  8  byte being folded in
// - next_crc out 8  CRC after absorbing data
// -----------------------------------------------------------------------------
module du_crc8_byte
   import du_pkg::*;
(
   input  logic [7:0] crc,
   input  logic [7:0] data,
   output logic [7:0] next_crc
);

   logic [7:0] crc_work;

   // XOR the byte in up front, then run eight shift/conditional-XOR steps.
   always_comb begin
      crc_work = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         if (crc_work[7]) begin
            crc_work = (crc_work << 1) ^ DU_CRC8_POLY;
         end else begin
            crc_work = crc_work << 1;
         end
      end
      next_crc = crc_work;
   end

endmodule

// File: rtl/du_latch_dump.sv
// -----------------------------------------------------------------------------
// du_latch_dump
// Freezes N_CH pipeline-latch vectors on request and streams the selected
// channels byte by byte into the UART TX FIFO, honouring FIFO-full.
// Each enabled channel is framed as {DU_HDR_TAG, ch[3:0]} followed by
// ceil(NB_CH/8) data bytes, most significant byte first.
// Optional feature macro: DU_DUMP_CRC8_EN appends one CRC-8 byte covering
// every header and data byte of the dump.
// Ports:
// - i_clk      in  1           system clock
// - i_reset    in  1           synchronous active-high reset
// - i_latches  in  N_CH*NB_CH  channel k at [k*NB_CH +: NB_CH]
// - i_ch_mask  in  N_CH        channel enable mask, sampled with i_start
// - i_start    in  1           dump request, honoured only in IDLE
// - i_tx_full  in  1           TX FIFO full, stalls the stream
// - o_tx_data  out NB_BYTE     byte to TX FIFO
// - o_tx_wr    out 1           write strobe for o_tx_data
// - o_busy     out 1           dump in progress
// - o_done     out 1           one-cycle completion pulse
// -----------------------------------------------------------------------------
module du_latch_dump
   import du_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int NB_CH   = 136,
   parameter int NB_BYTE = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [N_CH*NB_CH-1:0]   i_latches,
   input  logic [N_CH-1:0]         i_ch_mask,
   input  logic                    i_start,
   input  logic                    i_tx_full,
   output logic [NB_BYTE-1:0]      o_tx_data,
   output logic                    o_tx_wr,
   output logic                    o_busy,
   output logic                    o_done
);

   localparam int NBYTES = (NB_CH + 7) / 8;
   localparam int PAD_W  = NBYTES * 8;
   localparam int CNT_W  = $clog2(NBYTES + 1);
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

   generate
      if (N_CH < 1 || N_CH > 16 || NB_BYTE != 8) begin : g_bad_cfg
         $error("du_latch_dump: N_CH must be 1..16 and NB_BYTE must be 8");
      end
   endgenerate

`ifdef DU_DUMP_CRC8_EN
   localparam du_state_t END_ST = CRC;
`else
   localparam du_state_t END_ST = DONE;
`endif

   du_state_t               state;
   logic [N_CH*NB_CH-1:0]   snap;
   logic [N_CH-1:0]         mask;
   logic [CH_W-1:0]         ch_idx;
   logic [CNT_W-1:0]        byte_cnt;

   logic [PAD_W-1:0]        cur_pad;
   logic [7:0]              hdr_byte;
   logic [7:0]              data_byte;
   logic [7:0]              tx_byte;
   logic [CH_W:0]           first_ch;
   logic [CH_W:0]           next_ch;
   logic                    streaming;

   // Lowest enabled channel at or above 'from'; MSB of the result flags a hit.
   function automatic logic [CH_W:0] find_from(input logic [N_CH-1:0] m,
                                               input int from);
      logic [CH_W:0] r;
      r = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (m[k] && k >= from) begin
            r = {1'b1, CH_W'(k)};
         end
      end
      return r;
   endfunction

   assign first_ch = find_from(i_ch_mask, 0);
   assign next_ch  = find_from(mask, int'(ch_idx) + 1);

   // Current channel zero-padded up to a whole number of bytes, then the
   // byte picked MSB-first by the per-channel byte counter.
   assign cur_pad   = PAD_W'(snap[int'(ch_idx)*NB_CH +: NB_CH]);
   assign data_byte = cur_pad[(NBYTES - 1 - int'(byte_cnt))*8 +: 8];
   assign hdr_byte  = {DU_HDR_TAG, 4'(ch_idx)};

   assign streaming = (state == HDR) || (state == DATA) || (state == CRC);

`ifdef DU_DUMP_CRC8_EN
   logic [7:0] crc;
   logic [7:0] crc_next;

   du_crc8_byte u_crc8 (
      .crc      (crc),
      .data     (tx_byte),
      .next_crc (crc_next)
   );
`endif

   // Byte presented to the FIFO is decoded straight from the state so a
   // stall simply holds it until the FIFO has room again.
   always_comb begin
      tx_byte = '0;
      case (state)
         HDR:     tx_byte = hdr_byte;
         DATA:    tx_byte = data_byte;
`ifdef DU_DUMP_CRC8_EN
         CRC:     tx_byte = crc;
`endif
         default: tx_byte = '0;
      endcase
   end

   assign o_tx_wr   = streaming && !i_tx_full;
   assign o_tx_data = tx_byte;
   assign o_busy    = streaming;
   assign o_done    = (state == DONE);

   // Dump sequencer. Snapshot and mask are captured once at acceptance so
   // the running pipeline cannot disturb a dump in flight.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= IDLE;
         snap     <= '0;
         mask     <= '0;
         ch_idx   <= '0;
         byte_cnt <= '0;
`ifdef DU_DUMP_CRC8_EN
         crc      <= DU_CRC8_INIT;
`endif
      end else begin
`ifdef DU_DUMP_CRC8_EN
         if (o_tx_wr && state != CRC) begin
            crc <= crc_next;
         end
`endif
         case (state)
            IDLE: begin
               if (i_start) begin
                  snap     <= i_latches;
                  mask     <= i_ch_mask;
                  byte_cnt <= '0;
`ifdef DU_DUMP_CRC8_EN
                  crc      <= DU_CRC8_INIT;
`endif
                  if (first_ch[CH_W]) begin
                     ch_idx <= first_ch[CH_W-1:0];
                     state  <= HDR;
                  end else begin
                     state  <= END_ST;
                  end
               end
            end
            HDR: begin
               if (!i_tx_full) begin
                  byte_cnt <= '0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (!i_tx_full) begin
                  if (byte_cnt == CNT_W'(NBYTES - 1)) begin
                     if (next_ch[CH_W]) begin
                        ch_idx <= next_ch[CH_W-1:0];
                        state  <= HDR;
                     end else begin
                        state  <= END_ST;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
`ifdef DU_DUMP_CRC8_EN
            CRC: begin
               if (!i_tx_full) begin
                  state <= DONE;
               end
            end
`endif
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
